// File: rtl/phy_tx_pkg.sv
// Shared TX/RX PHY lane definitions: idle comma word, lane FSM encoding, frame length.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package phy_tx_pkg;

  // K28.5 comma byte; an idle lane word is four of these back to back.
  localparam logic [7:0]  IDLE_COM       = 8'hBC;
  localparam logic [31:0] IDLE_WORD_DFLT = {4{IDLE_COM}};

  // Lane framing state: IDLE frames carry commas, DATA frames carry a payload word.
  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } lane_state_t;

  // Serial frame length in bit times; the optional parity bit trails the word LSB.
  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

endpackage

// File: rtl/lane_serializer.sv
// Per-lane parallel-to-serial: word loaded at the load slot, MSB-first, idle commas when no data.
// Latency: MSB on data_out one edge after the load edge; frames back-to-back, no gap bits.
// Backpressure: ready_out pulses one cycle per frame; upstream holds its word until then.
// Optional feature macro: LANE_PARITY_EN appends an even-parity bit to every frame.
module lane_serializer
  import phy_tx_pkg::*;
#(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  IDLE_WORD = IDLE_WORD_DFLT
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             valid_out,
  output logic             active_out
);

`ifdef LANE_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int               FRAME = frame_len(WIDTH, PARITY_EN);
  localparam int               CNT_W = $clog2(FRAME);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME - 1);

  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  lane_state_t      state;
  lane_state_t      state_nxt;
  logic             load;
  logic             frame_bit;

  // Bit-time counter; wraps at the end of each frame so the load slot recurs every FRAME cycles.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset)     bit_cnt <= '0;
    else if (load) bit_cnt <= '0;
    else           bit_cnt <= bit_cnt + CNT_W'(1);
  end

  // Lane FSM state register.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: the frame type is only decided at the load slot.
  always_comb begin
    state_nxt = state;
    if (load) state_nxt = valid_in ? DATA : IDLE;
  end

  // Load slot decode from the registered counter, so it stays low while in reset.
  always_comb begin
    load      = (bit_cnt == LAST);
    ready_out = load;
  end

  // Shifter: load the accepted word (or idle) at the slot, otherwise shift toward the MSB.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset)     shift_reg <= IDLE_WORD;
    else if (load) shift_reg <= valid_in ? data_in : IDLE_WORD;
    else           shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
  end

`ifdef LANE_PARITY_EN
  logic par_bit;

  // Even parity of the frame's word, captured at load and sent in the last bit time.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset)     par_bit <= ^IDLE_WORD;
    else if (load) par_bit <= valid_in ? ^data_in : ^IDLE_WORD;
  end

  // The load edge itself carries the parity bit of the outgoing frame.
  assign frame_bit = load ? par_bit : shift_reg[WIDTH-1];
`else
  // The load edge itself carries the LSB of the outgoing frame.
  assign frame_bit = shift_reg[WIDTH-1];
`endif

  // Registered serial output; valid follows the type of the frame currently on the wire.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      data_out  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      data_out  <= frame_bit;
      valid_out <= (state == DATA);
    end
  end

  // Sticky link-active flag, set on the first data frame after reset.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset)                                   active_out <= 1'b0;
    else if (state == IDLE && state_nxt == DATA) active_out <= 1'b1;
  end

endmodule
